// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 camera capture path.
//   - default frame geometry and frame-buffer address width
//   - capture FSM state encoding
//   - RGB565 -> RGB332 packing function
//   - RGB332 colour constants used by the VGA path and the image processor
package cam_pkg;

  localparam int SCREEN_WIDTH_DEF  = 176;
  localparam int SCREEN_HEIGHT_DEF = 144;
  localparam int ADDR_W_DEF        = 15;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    WAIT_LINE  = 2'd1,
    LINE       = 2'd2
  } cam_state_t;

  localparam logic [7:0] RED   = 8'hE0;
  localparam logic [7:0] GREEN = 8'h1C;
  localparam logic [7:0] BLUE  = 8'h03;

  // The camera's high byte carries R[4:0],G[5:3]; the low byte carries
  // G[2:0],B[4:0]. The stored pixel keeps R[4:2], G[5:3] and B[4:3].
  function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] hi,
                                                  input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Input register stage for the OV7670 parallel bus plus edge detectors.
// Ports:
//   i_clk, i_rst           pixel clock, synchronous active-high reset
//   i_vsync, i_href        raw camera framing signals
//   i_data                 raw camera data byte
//   o_vs                   registered VSYNC level
//   o_vs_rise, o_vs_fall   VSYNC edges (registered copy vs. its delayed copy)
//   o_hr_rise, o_hr_fall   HREF edges
//   o_data                 registered data byte, aligned with the edge flags
module cam_sync_edge
  import cam_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_vsync,
  input  logic       i_href,
  input  logic [7:0] i_data,
  output logic       o_vs,
  output logic       o_vs_rise,
  output logic       o_vs_fall,
  output logic       o_hr_rise,
  output logic       o_hr_fall,
  output logic [7:0] o_data
);

  logic       r_vs_q;
  logic       r_vs_qq;
  logic       r_hr_q;
  logic       r_hr_qq;
  logic [7:0] r_d_q;

  // Framing registers clear to 0: a VSYNC already high at reset release
  // only shows up as a rising edge, which the capture FSM ignores while
  // waiting for a frame, so no spurious frame start can be produced.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vs_q  <= 1'b0;
      r_vs_qq <= 1'b0;
      r_hr_q  <= 1'b0;
      r_hr_qq <= 1'b0;
    end else begin
      r_vs_q  <= i_vsync;
      r_vs_qq <= r_vs_q;
      r_hr_q  <= i_href;
      r_hr_qq <= r_hr_q;
    end
  end

  always_ff @(posedge i_clk) begin
    r_d_q <= i_data;
  end

  assign o_vs      = r_vs_q;
  assign o_vs_rise =  r_vs_q & ~r_vs_qq;
  assign o_vs_fall = ~r_vs_q &  r_vs_qq;
  assign o_hr_rise =  r_hr_q & ~r_hr_qq;
  assign o_hr_fall = ~r_hr_q &  r_hr_qq;
  assign o_data    = r_d_q;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 capture / frame-buffer write stage.
// Packs RGB565 byte pairs into RGB332 pixels and writes them to a
// SCREEN_WIDTH x SCREEN_HEIGHT frame buffer, reporting per-frame status.
// SCREEN_WIDTH*SCREEN_HEIGHT must fit in 2**ADDR_W addresses.
// Ports:
//   CLK, RESET                 pixel clock, synchronous active-high reset
//   CAM_VSYNC, CAM_HREF        camera framing (VSYNC high = blanking)
//   CAM_DATA                   camera byte, two per pixel (hi then lo)
//   W_ADDR, W_DATA, W_EN       frame-buffer write port (one strobe per pixel)
//   FRAME_DONE                 one-cycle pulse at end of each captured frame
//   FRAME_OK                   last frame complete and error free
//   ERR_STICKY                 any framing error since reset
module ov7670_capture
  import cam_pkg::*;
#(
  parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int ADDR_W        = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CAM_VSYNC,
  input  logic              CAM_HREF,
  input  logic [7:0]        CAM_DATA,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              W_EN,
  output logic              FRAME_DONE,
  output logic              FRAME_OK,
  output logic              ERR_STICKY
);

  localparam int XW = $clog2(SCREEN_WIDTH + 1);
  localparam int YW = $clog2(SCREEN_HEIGHT + 1);
  localparam logic [XW-1:0]     X_END    = XW'(SCREEN_WIDTH);
  localparam logic [YW-1:0]     Y_END    = YW'(SCREEN_HEIGHT);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SCREEN_WIDTH);

  logic       w_vs;
  logic       w_vs_rise;
  logic       w_vs_fall;
  logic       w_hr_rise;
  logic       w_hr_fall;
  logic [7:0] w_d;

  cam_sync_edge u_sync (
    .i_clk     (CLK),
    .i_rst     (RESET),
    .i_vsync   (CAM_VSYNC),
    .i_href    (CAM_HREF),
    .i_data    (CAM_DATA),
    .o_vs      (w_vs),
    .o_vs_rise (w_vs_rise),
    .o_vs_fall (w_vs_fall),
    .o_hr_rise (w_hr_rise),
    .o_hr_fall (w_hr_fall),
    .o_data    (w_d)
  );

  cam_state_t        r_state,      w_state_n;
  logic [XW-1:0]     r_x,          w_x_n;
  logic [YW-1:0]     r_y,          w_y_n;
  logic [ADDR_W-1:0] r_row_base,   w_row_base_n;
  logic              r_phase,      w_phase_n;
  logic [7:0]        r_hi,         w_hi_n;
  logic              r_frame_good, w_good_n;
  logic              r_err,        w_err_n;
  logic [ADDR_W-1:0] r_w_addr,     w_addr_n;
  logic [7:0]        r_w_data,     w_data_n;
  logic              r_w_en,       w_en_n;
  logic              r_done,       w_done_n;
  logic              r_ok,         w_ok_n;

  // y saturates at SCREEN_HEIGHT, so y == SCREEN_HEIGHT inside LINE means
  // the current line began past the last stored row and is being dropped.
  always_comb begin
    w_state_n    = r_state;
    w_x_n        = r_x;
    w_y_n        = r_y;
    w_row_base_n = r_row_base;
    w_phase_n    = r_phase;
    w_hi_n       = r_hi;
    w_good_n     = r_frame_good;
    w_err_n      = r_err;
    w_addr_n     = r_w_addr;
    w_data_n     = r_w_data;
    w_en_n       = 1'b0;
    w_done_n     = 1'b0;
    w_ok_n       = r_ok;

    unique case (r_state)
      WAIT_FRAME: begin
        if (w_vs_fall) begin
          w_state_n    = WAIT_LINE;
          w_x_n        = '0;
          w_y_n        = '0;
          w_row_base_n = '0;
          w_phase_n    = 1'b0;
          w_good_n     = 1'b1;
        end
      end

      WAIT_LINE: begin
        if (w_vs_rise) begin
          w_state_n = WAIT_FRAME;
          w_done_n  = 1'b1;
          w_ok_n    = r_frame_good && (r_y == Y_END);
        end else if (w_hr_rise && !w_vs) begin
          // The byte arriving with the HREF edge is the first hi byte.
          w_state_n = LINE;
          w_x_n     = '0;
          w_hi_n    = w_d;
          w_phase_n = 1'b1;
          if (r_y == Y_END) begin
            w_good_n = 1'b0;
            w_err_n  = 1'b1;
          end
        end
      end

      LINE: begin
        if (w_hr_fall || w_vs_rise) begin
          // Line-end accounting happens before any end-of-frame status so
          // that FRAME_OK sees the updated row count. A VSYNC rise without
          // HREF falling means the line was cut off.
          w_x_n     = '0;
          w_phase_n = 1'b0;
          if (r_y != Y_END) begin
            if ((r_x != X_END) || r_phase || !w_hr_fall) begin
              w_good_n = 1'b0;
              w_err_n  = 1'b1;
            end
            w_y_n        = r_y + YW'(1);
            w_row_base_n = r_row_base + ROW_STEP;
          end
          if (w_vs_rise) begin
            w_state_n = WAIT_FRAME;
            w_done_n  = 1'b1;
            w_ok_n    = w_good_n && (w_y_n == Y_END);
          end else begin
            w_state_n = WAIT_LINE;
          end
        end else if (r_y != Y_END) begin
          if (!r_phase) begin
            w_hi_n    = w_d;
            w_phase_n = 1'b1;
          end else begin
            w_phase_n = 1'b0;
            if (r_x != X_END) begin
              w_en_n   = 1'b1;
              w_addr_n = r_row_base + ADDR_W'(r_x);
              w_data_n = rgb565_to_rgb332(r_hi, w_d);
              w_x_n    = r_x + XW'(1);
            end else begin
              w_good_n = 1'b0;
              w_err_n  = 1'b1;
            end
          end
        end
      end

      default: w_state_n = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= WAIT_FRAME;
      r_x          <= '0;
      r_y          <= '0;
      r_row_base   <= '0;
      r_phase      <= 1'b0;
      r_frame_good <= 1'b0;
      r_err        <= 1'b0;
      r_w_addr     <= '0;
      r_w_data     <= '0;
      r_w_en       <= 1'b0;
      r_done       <= 1'b0;
      r_ok         <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_x          <= w_x_n;
      r_y          <= w_y_n;
      r_row_base   <= w_row_base_n;
      r_phase      <= w_phase_n;
      r_frame_good <= w_good_n;
      r_err        <= w_err_n;
      r_w_addr     <= w_addr_n;
      r_w_data     <= w_data_n;
      r_w_en       <= w_en_n;
      r_done       <= w_done_n;
      r_ok         <= w_ok_n;
    end
  end

  // Held hi byte is pure data and needs no reset.
  always_ff @(posedge CLK) begin
    r_hi <= w_hi_n;
  end

  assign W_ADDR     = r_w_addr;
  assign W_DATA     = r_w_data;
  assign W_EN       = r_w_en;
  assign FRAME_DONE = r_done;
  assign FRAME_OK   = r_ok;
  assign ERR_STICKY = r_err;

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture on a reduced 10x6 frame. The reference model
// works per frame: from the list of line byte counts it predicts every
// frame-buffer write (address = line*W + pixel, with the clock cycle it
// must appear on) and every FRAME_DONE with its FRAME_OK / ERR_STICKY.
module tb_ov7670_capture;

  localparam int W  = 10;
  localparam int H  = 6;
  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          CAM_VSYNC;
  logic          CAM_HREF;
  logic [7:0]    CAM_DATA;
  logic [AW-1:0] W_ADDR;
  logic [7:0]    W_DATA;
  logic          W_EN;
  logic          FRAME_DONE;
  logic          FRAME_OK;
  logic          ERR_STICKY;

  ov7670_capture #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .ADDR_W(AW)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .CAM_VSYNC  (CAM_VSYNC),
    .CAM_HREF   (CAM_HREF),
    .CAM_DATA   (CAM_DATA),
    .W_ADDR     (W_ADDR),
    .W_DATA     (W_DATA),
    .W_EN       (W_EN),
    .FRAME_DONE (FRAME_DONE),
    .FRAME_OK   (FRAME_OK),
    .ERR_STICKY (ERR_STICKY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pack(input logic [7:0] h, input logic [7:0] l);
    return {h[7:5], h[2:0], l[4:3]};
  endfunction

  typedef struct { int cyc; int addr; int data; } wr_t;
  typedef struct { int cyc; bit ok; bit err; } fd_t;

  wr_t wq[$];
  fd_t fq[$];
  wr_t e;
  fd_t f;

  bit chk_on      = 1'b0;
  int rst_chk_cyc = -1;
  int wr_cnt      = 0;
  int last_addr   = -1;
  int first_addr  = -1;
  int first_data  = -1;
  bit err_m       = 1'b0;
  int line_len[0:15];

  // Single compare process: every cycle the write port and the frame
  // pulse must match what the model scheduled for that cycle.
  always @(negedge CLK) begin
    if (chk_on) begin
      if (cyc == rst_chk_cyc) begin
        chk("rst_w_addr", W_ADDR, 0);
        chk("rst_w_data", W_DATA, 0);
        chk("rst_frame_ok", FRAME_OK, 0);
        chk("rst_err_sticky", ERR_STICKY, 0);
      end
      if (wq.size() > 0 && wq[0].cyc == cyc) begin
        e = wq.pop_front();
        chk("w_en", W_EN, 1);
        chk("w_addr", W_ADDR, e.addr);
        chk("w_data", W_DATA, e.data);
      end else begin
        chk("w_en_idle", W_EN, 0);
      end
      if (W_EN === 1'b1) begin
        if (wr_cnt == 0) begin
          first_addr = int'(W_ADDR);
          first_data = int'(W_DATA);
        end
        wr_cnt++;
        last_addr = int'(W_ADDR);
      end
      if (fq.size() > 0 && fq[0].cyc == cyc) begin
        f = fq.pop_front();
        chk("frame_done", FRAME_DONE, 1);
        chk("frame_ok", FRAME_OK, 32'(f.ok));
        chk("err_sticky", ERR_STICKY, 32'(f.err));
      end else begin
        chk("frame_done_idle", FRAME_DONE, 0);
      end
    end
  end

  task automatic tick(input logic vs, input logic hr, input logic [7:0] d, input logic rst);
    @(posedge CLK);
    #1;
    CAM_VSYNC = vs;
    CAM_HREF  = hr;
    CAM_DATA  = d;
    RESET     = rst;
  endtask

  task automatic set_nominal();
    for (int i = 0; i < 16; i++) line_len[i] = 2 * W;
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    rst_chk_cyc = cyc + 1;
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    err_m = 1'b0;
  endtask

  // pmode 0: random bytes, 1: hi=E0 lo=00, 2: first pixel A5/5A then random
  task automatic run_frame(input int nlines, input bit simul, input int rst_line,
                           input int rst_byte, input int pmode);
    bit         bad;
    bit         aborted;
    bit         r;
    logic [7:0] hi;
    logic [7:0] b8;
    int         n;
    bad     = 1'b0;
    aborted = 1'b0;
    hi      = 8'h00;
    n       = 0;
    wr_cnt  = 0;
    tick(1'b1, 1'b0, 8'($urandom), 1'b0);
    tick(1'b0, 1'b0, 8'($urandom), 1'b0);
    repeat (2 + $urandom_range(0, 1)) tick(1'b0, 1'b0, 8'($urandom), 1'b0);
    for (int li = 0; li < nlines; li++) begin
      for (int b = 0; b < line_len[li]; b++) begin
        r = (li == rst_line) && (b == rst_byte);
        if (pmode == 1)                      b8 = (b % 2 == 0) ? 8'hE0 : 8'h00;
        else if (pmode == 2 && li == 0 && b == 0) b8 = 8'hA5;
        else if (pmode == 2 && li == 0 && b == 1) b8 = 8'h5A;
        else                                 b8 = 8'($urandom);
        tick(1'b0, 1'b1, b8, r);
        n = cyc;
        if (b % 2 == 0) begin
          hi = b8;
        end else if (!aborted && li < H && (b / 2) < W) begin
          wq.push_back('{n + 2, li * W + b / 2, int'(pack(hi, b8))});
        end
        if (r) begin
          aborted = 1'b1;
          bad     = 1'b0;
          err_m   = 1'b0;
          while (wq.size() > 0 && wq[$].cyc >= n + 1) void'(wq.pop_back());
          rst_chk_cyc = n + 1;
        end
      end
      if (!aborted && (li >= H || line_len[li] != 2 * W)) bad = 1'b1;
      if (li == nlines - 1 && simul) begin
        tick(1'b1, 1'b0, 8'($urandom), 1'b0);
        n = cyc;
      end else begin
        repeat (1 + $urandom_range(0, 2)) tick(1'b0, 1'b0, 8'($urandom), 1'b0);
      end
    end
    if (!simul) begin
      tick(1'b1, 1'b0, 8'($urandom), 1'b0);
      n = cyc;
    end
    if (!aborted) begin
      err_m = err_m | bad;
      fq.push_back('{n + 2, !bad && (nlines >= H), err_m});
    end
    repeat (4) tick(1'b1, 1'b0, 8'($urandom), 1'b0);
  endtask

  int lens_tbl[8];
  int nl;

  initial begin
    RESET     = 1'b1;
    CAM_VSYNC = 1'b1;
    CAM_HREF  = 1'b0;
    CAM_DATA  = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_w_en", W_EN, 0);
    chk("reset_w_addr", W_ADDR, 0);
    chk("reset_w_data", W_DATA, 0);
    chk("reset_frame_done", FRAME_DONE, 0);
    chk("reset_frame_ok", FRAME_OK, 0);
    chk("reset_err_sticky", ERR_STICKY, 0);
    RESET  = 1'b0;
    chk_on = 1'b1;

    // nominal frame
    set_nominal();
    run_frame(H, 1'b0, -1, -1, 1);
    chk("nom_writes", wr_cnt, 60);
    chk("nom_last_addr", last_addr, 59);
    chk("nom_first_data", first_data, 32'hE0);
    chk("nom_ok_pin", FRAME_OK, 1);
    chk("nom_err_pin", ERR_STICKY, 0);

    // packing of the first pixel
    run_frame(H, 1'b0, -1, -1, 2);
    chk("pack_first_addr", first_addr, 0);
    chk("pack_first_data", first_data, 32'hB7);
    chk("pack_writes", wr_cnt, 60);

    // long line 3
    line_len[3] = 2 * W + 2;
    run_frame(H, 1'b0, -1, -1, 0);
    chk("long_writes", wr_cnt, 60);
    chk("long_ok_pin", FRAME_OK, 0);
    chk("long_err_pin", ERR_STICKY, 1);
    do_reset();

    // short/odd line 0
    set_nominal();
    line_len[0] = 2 * W - 1;
    run_frame(H, 1'b0, -1, -1, 0);
    chk("short_writes", wr_cnt, 59);
    chk("short_ok_pin", FRAME_OK, 0);
    chk("short_err_pin", ERR_STICKY, 1);
    do_reset();

    // extra lines
    set_nominal();
    run_frame(H + 2, 1'b0, -1, -1, 0);
    chk("extra_writes", wr_cnt, 60);
    chk("extra_last_addr", last_addr, 59);
    chk("extra_ok_pin", FRAME_OK, 0);
    do_reset();

    // reset in the middle of line 3, then a clean frame
    run_frame(H, 1'b0, 3, 7, 0);
    run_frame(H, 1'b0, -1, -1, 0);
    chk("post_rst_writes", wr_cnt, 60);
    chk("post_rst_ok_pin", FRAME_OK, 1);

    // HREF fall coincident with VSYNC rise on the last line
    run_frame(H, 1'b1, -1, -1, 0);
    chk("simul_ok_pin", FRAME_OK, 1);

    // too few lines: not OK but no framing error
    run_frame(H - 1, 1'b0, -1, -1, 0);
    chk("few_writes", wr_cnt, 50);
    chk("few_ok_pin", FRAME_OK, 0);
    chk("few_err_pin", ERR_STICKY, 0);

    // randomized frames
    lens_tbl = '{2*W, 2*W, 2*W, 2*W - 1, 2*W + 1, 2*W + 2, 2*W - 4, 2};
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 16; i++)
        line_len[i] = ($urandom_range(0, 2) == 0) ? lens_tbl[$urandom_range(0, 7)] : 2 * W;
      nl = $urandom_range(H - 1, H + 1);
      if ($urandom_range(0, 5) == 0) begin
        int rl;
        rl = $urandom_range(0, nl - 1);
        run_frame(nl, 1'($urandom_range(0, 1)), rl, $urandom_range(0, line_len[rl] - 1), 0);
      end else begin
        run_frame(nl, 1'($urandom_range(0, 1)), -1, -1, 0);
      end
    end

    repeat (4) tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk("writes_drained", wq.size(), 0);
    chk("frames_drained", fq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
